// File: rtl/hazard_sched.sv
// Hazard scheduler for the 5-stage RV32I pipe: EX/MEM scoreboard, operand forwarding,
// load-use stall, redirect flush and whole-pipe freeze on outstanding data-memory access.
module hazard_sched #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_rs1use,
  input  logic       id_rs2use,
  input  logic [1:0] id_optype,
  input  logic [4:0] id_rd,
  input  logic       id_regwrite,
  input  logic       id_redirect,
  input  logic       dmem_req,
  input  logic       dmem_ack,
  output logic       stall_pc,
  output logic       stall_ifid,
  output logic       flush_ifid,
  output logic       bubble_idex,
  output logic       freeze,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       mem_err
);
  localparam int CW = $clog2(MEM_TIMEOUT) + 1;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwrite;
    logic       is_load;
  } sb_ent_t;

  typedef enum logic [1:0] {IDLE, WAIT, ERR} mstate_t;

  mstate_t        state, state_nx;
  logic [CW-1:0]  cnt, cnt_nx;
  logic           frz, load_use;
  sb_ent_t        ex_q, mem_q;

  function automatic logic hit(input sb_ent_t e, input logic [4:0] rs);
    return e.valid & e.regwrite & (e.rd != 5'd0) & (e.rd == rs);
  endfunction

  // EX wins over MEM; a load still in EX has no data yet, so it cannot be the source.
  function automatic logic [1:0] fwd_sel(input logic used, input logic [4:0] rs,
                                         input sb_ent_t ex, input sb_ent_t mem);
    if (!used || rs == 5'd0) return 2'b00;
    if (hit(ex, rs) && !ex.is_load) return 2'b01;
    if (hit(mem, rs)) return mem.is_load ? 2'b11 : 2'b10;
    return 2'b00;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Freeze is raised in the same cycle the access is issued, so no cycle is lost.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    frz      = 1'b0;
    unique case (state)
      IDLE: if (dmem_req && !dmem_ack) begin
        state_nx = WAIT;
        cnt_nx   = CW'(1);
        frz      = 1'b1;
      end
      WAIT: begin
        frz = 1'b1;
        if (dmem_ack) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt == CW'(MEM_TIMEOUT - 1)) begin
          state_nx = ERR;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      ERR:     frz = 1'b1;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    load_use = id_valid & ex_q.is_load &
               ((id_rs1use & hit(ex_q, id_rs1)) | (id_rs2use & hit(ex_q, id_rs2)));
  end

  assign freeze      = frz & ~rst;
  assign stall_pc    = load_use & ~frz & ~rst;
  assign stall_ifid  = stall_pc;
  assign bubble_idex = stall_pc;
  assign flush_ifid  = id_redirect & ~load_use & ~frz & ~rst;
  assign mem_err     = (state == ERR);
  assign fwd_a       = fwd_sel(id_valid & id_rs1use, id_rs1, ex_q, mem_q);
  assign fwd_b       = fwd_sel(id_valid & id_rs2use, id_rs2, ex_q, mem_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
    end else if (!frz) begin
      mem_q <= ex_q;
      if (load_use) ex_q <= '0;
      else          ex_q <= '{valid: id_valid, rd: id_rd, regwrite: id_regwrite,
                              is_load: (id_optype == 2'b00)};
    end
  end
endmodule
